uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_if.sv | 21 ++
 rtl/uart_cmd_parser.sv | 131 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: byte stream in, payload writes and frame results out.
interface uart_cmd_parser_if;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic       o_Wr_En;
    logic [3:0] o_Wr_Addr;
    logic [7:0] o_Wr_Data;
    logic       o_Cmd_Valid;
    logic [7:0] o_Cmd;
    logic [4:0] o_Cmd_Len;
    logic       o_Err;
    logic [1:0] o_Err_Code;
    modport slave (
        input  i_Rx_DV, i_Rx_Byte,
        output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Cmd_Valid, o_Cmd, o_Cmd_Len, o_Err, o_Err_Code
    );
    modport master (
        output i_Rx_DV, i_Rx_Byte,
        input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Cmd_Valid, o_Cmd, o_Cmd_Len, o_Err, o_Err_Code
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses A5/CMD/LEN/payload/CHK frames from a UART byte stream.
module uart_cmd_parser #(
    parameter int TIMEOUT_CLKS = 8700,
    parameter int MAX_LEN      = 16
) (
    input logic              i_Clock,
    input logic              i_Reset_n,
    uart_cmd_parser_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHECK} state_t;
    state_t     state_q, state_d;
    logic [7:0] pcmd_q, pcmd_d, chk_q, chk_d;
    logic [4:0] len_q, len_d, idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       wr_en_q, wr_en_d, valid_q, valid_d, err_q, err_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d, cmd_q, cmd_d;
    logic [4:0] cmd_len_q, cmd_len_d;
    logic [1:0] code_q, code_d;
    logic       dv, expired;
    logic [7:0] b;
    assign dv = bus.i_Rx_DV;
    assign b  = bus.i_Rx_Byte;
    // A byte on the expiry cycle wins: expiry requires no i_Rx_DV.
    assign expired = (state_q != S_IDLE) && !dv && (cnt_q == CW'(TIMEOUT_CLKS - 1));
    always_comb begin
        state_d   = state_q;
        pcmd_d    = pcmd_q;
        chk_d     = chk_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = (state_q == S_IDLE || dv) ? '0 : cnt_q + 1'b1;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        valid_d   = 1'b0;
        cmd_d     = cmd_q;
        cmd_len_d = cmd_len_q;
        err_d     = 1'b0;
        code_d    = code_q;
        if (expired) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (dv) begin
            case (state_q)
                S_IDLE: state_d = (b == 8'hA5) ? S_CMD : S_IDLE;
                S_CMD: begin
                    pcmd_d  = b;
                    chk_d   = b;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    chk_d = chk_q ^ b;
                    len_d = b[4:0];
                    idx_d = '0;
                    if (b > 8'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = S_IDLE;
                    end else begin
                        state_d = (b == 8'h00) ? S_CHECK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[3:0];
                    wr_data_d = b;
                    chk_d     = chk_q ^ b;
                    idx_d     = idx_q + 5'd1;
                    state_d   = (idx_q == len_q - 5'd1) ? S_CHECK : S_PAYLOAD;
                end
                S_CHECK: begin
                    if (b == chk_q) begin
                        valid_d   = 1'b1;
                        cmd_d     = pcmd_q;
                        cmd_len_d = len_q;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'b01;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            pcmd_q    <= '0;
            chk_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            valid_q   <= 1'b0;
            cmd_q     <= '0;
            cmd_len_q <= '0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            pcmd_q    <= pcmd_d;
            chk_q     <= chk_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            cmd_len_q <= cmd_len_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end
    assign bus.o_Wr_En     = wr_en_q;
    assign bus.o_Wr_Addr   = wr_addr_q;
    assign bus.o_Wr_Data   = wr_data_q;
    assign bus.o_Cmd_Valid = valid_q;
    assign bus.o_Cmd       = cmd_q;
    assign bus.o_Cmd_Len   = cmd_len_q;
    assign bus.o_Err       = err_q;
    assign bus.o_Err_Code  = code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and random frames checked against a byte-queue frame model.
module tb_uart_cmd_parser;
    localparam int T   = 20;
    localparam int MAX = 16;
    typedef logic [7:0] bq_t[$];
    logic clk, rst_n;
    int checks = 0, errors = 0;
    uart_cmd_parser_if bus();
    uart_cmd_parser #(.TIMEOUT_CLKS(T), .MAX_LEN(MAX)) dut (.i_Clock(clk), .i_Reset_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [7:0] fq[$];
    bit         in_frame = 0;
    int         since = 0;
    logic [7:0] m_cmd = 0;
    logic [4:0] m_len = 0;
    logic [1:0] m_code = 0;
    logic       e_wr, e_valid, e_err;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Frame model: bytes after the sync are collected; position in the queue decides meaning.
    task automatic model_byte(input logic [7:0] b);
        int n;
        logic [7:0] x;
        if (!in_frame) begin
            in_frame = (b == 8'hA5);
            fq.delete();
            return;
        end
        fq.push_back(b);
        n = fq.size();
        if (n == 2 && int'(b) > MAX) begin
            e_err = 1; m_code = 2'b10; in_frame = 0;
        end else if (n >= 3 && n - 2 <= int'(fq[1])) begin
            e_wr = 1; e_addr = 4'(n - 3); e_data = b;
        end else if (n >= 3) begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x ^= fq[i];
            if (x == b) begin
                e_valid = 1; m_cmd = fq[0]; m_len = 5'(fq[1]);
            end else begin
                e_err = 1; m_code = 2'b01;
            end
            in_frame = 0;
        end
    endtask
    task automatic cyc(input bit dv, input logic [7:0] b);
        bus.i_Rx_DV = dv;
        bus.i_Rx_Byte = b;
        e_wr = 0; e_valid = 0; e_err = 0;
        if (dv) begin
            model_byte(b);
            since = 0;
        end else if (in_frame) begin
            since++;
            if (since == T) begin
                e_err = 1; m_code = 2'b11; in_frame = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.i_Rx_DV = 1'b0;
        chk("wr_en", bus.o_Wr_En, e_wr);
        if (e_wr) begin
            chk("wr_addr", bus.o_Wr_Addr, e_addr);
            chk("wr_data", bus.o_Wr_Data, e_data);
        end
        chk("cmd_valid", bus.o_Cmd_Valid, e_valid);
        chk("err", bus.o_Err, e_err);
        chk("cmd", bus.o_Cmd, m_cmd);
        chk("cmd_len", bus.o_Cmd_Len, m_len);
        chk("err_code", bus.o_Err_Code, m_code);
    endtask
    task automatic send(input bq_t bs);
        foreach (bs[i]) cyc(1'b1, bs[i]);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", bus.o_Wr_En, 0);
        chk("rst_wr_addr", bus.o_Wr_Addr, 0);
        chk("rst_wr_data", bus.o_Wr_Data, 0);
        chk("rst_valid", bus.o_Cmd_Valid, 0);
        chk("rst_cmd", bus.o_Cmd, 0);
        chk("rst_len", bus.o_Cmd_Len, 0);
        chk("rst_err", bus.o_Err, 0);
        chk("rst_code", bus.o_Err_Code, 0);
        rst_n = 1'b1;
        in_frame = 0; since = 0; m_cmd = 0; m_len = 0; m_code = 0;
    endtask
    initial begin
        bus.i_Rx_DV = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        do_reset();
        send('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33});
        send('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34});
        send('{8'hA5, 8'h05, 8'h11});
        send('{8'hA5, 8'h07, 8'h00, 8'h07});
        send('{8'hA5, 8'h03});
        idle(T + 3);
        send('{8'h5A, 8'h00, 8'hA5, 8'h01, 8'h00, 8'h01});
        send('{8'hA5, 8'h09});
        idle(T - 1);
        send('{8'h01, 8'h42, 8'h4A});
        send('{8'hA5, 8'h02, 8'h04, 8'hAA});
        do_reset();
        send('{8'hAA, 8'hBB});
        idle(2);
        for (int f = 0; f < 150; f++) begin
            bq_t fr;
            logic [7:0] x;
            int len;
            if ($urandom_range(0, 3) == 0) cyc(1'b1, 8'($urandom));
            len = $urandom_range(0, MAX + 2);
            fr = '{8'hA5, 8'($urandom), 8'(len)};
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            x = 8'h00;
            for (int i = 1; i < fr.size(); i++) x ^= fr[i];
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            fr.push_back(x);
            foreach (fr[i]) begin
                idle(($urandom_range(0, 19) == 0) ? T - 1 + $urandom_range(0, 2) : $urandom_range(0, 2));
                cyc(1'b1, fr[i]);
            end
        end
        idle(T + 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
